// File: rtl/attiny_pkg.sv
// attiny_pkg: shared constants and loader state encoding for the program memory
package attiny_pkg;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WR, S_DONE} load_state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: assembles little-endian image bytes into words and sequences their writes
module prog_loader
  import attiny_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_en,
  input  logic [7:0]            prog_byte,
  input  logic                  prog_strobe,
  output logic                  core_hold,
  output logic                  prog_done,
  output logic                  prog_ovf,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [INSTR_W-1:0]    wdata
);
  load_state_t state, nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [7:0] lo, hi;
  logic full;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = prog_en ? S_LO : S_IDLE;
      S_LO:    nxt = !prog_en ? S_DONE : (prog_strobe && !full) ? S_HI : S_LO;
      S_HI:    nxt = !prog_en ? S_DONE : prog_strobe ? S_WR : S_HI;
      S_WR:    nxt = prog_en ? S_LO : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lo       <= '0;
      hi       <= '0;
      full     <= 1'b0;
      prog_ovf <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && prog_en) begin
        cnt      <= '0;
        full     <= 1'b0;
        prog_ovf <= 1'b0;
      end
      if (state == S_LO && prog_en && prog_strobe) begin
        if (full) prog_ovf <= 1'b1;
        else lo <= prog_byte;
      end
      if (state == S_HI && prog_en && prog_strobe) hi <= prog_byte;
      // the counter wraps after the last word, but full blocks any further write
      if (state == S_WR) begin
        cnt  <= cnt + 1'b1;
        full <= &cnt;
      end
    end
  end
  assign core_hold = state != S_IDLE;
  assign prog_done = state == S_DONE;
  assign we        = state == S_WR;
  assign waddr     = cnt;
  assign wdata     = {hi, lo};
endmodule

// File: rtl/prog_mem.sv
// prog_mem: loadable program memory with falling-edge fetch and lpm byte read ports
module prog_mem
  import attiny_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  lpm_req,
  input  logic [ADDR_WIDTH:0]   lpm_addr,
  output logic [7:0]            lpm_data,
  output logic                  lpm_valid,
  input  logic                  prog_en,
  input  logic [7:0]            prog_byte,
  input  logic                  prog_strobe,
  output logic                  core_hold,
  output logic                  prog_done,
  output logic                  prog_ovf
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [INSTR_W-1:0] wdata;
  logic [DATA_WIDTH-1:0] lw;
  prog_loader #(.ADDR_WIDTH(ADDR_WIDTH)) u_loader (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_byte(prog_byte),
    .prog_strobe(prog_strobe), .core_hold(core_hold), .prog_done(prog_done),
    .prog_ovf(prog_ovf), .we(we), .waddr(waddr), .wdata(wdata)
  );
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign lw = mem[lpm_addr[ADDR_WIDTH:1]];
  // reads on the falling edge so the core samples them at the next rising edge
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      lpm_data  <= '0;
      lpm_valid <= 1'b0;
    end else begin
      data      <= core_hold ? NOP_WORD : mem[addr];
      lpm_data  <= lpm_addr[0] ? lw[15:8] : lw[7:0];
      lpm_valid <= lpm_req & ~core_hold;
    end
  end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: random image sessions on a full-size and a 4-word memory against an array model
module tb_prog_mem;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] addr;
  logic [15:0] data;
  logic lpm_req;
  logic [10:0] lpm_addr;
  logic [7:0] lpm_data;
  logic lpm_valid;
  logic prog_en;
  logic [7:0] prog_byte;
  logic prog_strobe;
  logic core_hold, prog_done, prog_ovf;
  logic [1:0] s_addr;
  logic [15:0] s_data;
  logic [2:0] s_lpm_addr;
  logic [7:0] s_lpm_data;
  logic s_lpm_valid, s_hold, s_done, s_ovf;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mb [1024];
  bit vb [1024];
  logic [15:0] ms [4];
  bit vs [4];
  logic [7:0] q [$];

  always #5 clk = ~clk;

  prog_mem dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .lpm_req(lpm_req),
    .lpm_addr(lpm_addr), .lpm_data(lpm_data), .lpm_valid(lpm_valid),
    .prog_en(prog_en), .prog_byte(prog_byte), .prog_strobe(prog_strobe),
    .core_hold(core_hold), .prog_done(prog_done), .prog_ovf(prog_ovf)
  );

  prog_mem #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .addr(s_addr), .data(s_data), .lpm_req(lpm_req),
    .lpm_addr(s_lpm_addr), .lpm_data(s_lpm_data), .lpm_valid(s_lpm_valid),
    .prog_en(prog_en), .prog_byte(prog_byte), .prog_strobe(prog_strobe),
    .core_hold(s_hold), .prog_done(s_done), .prog_ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic session();
    int n = q.size();
    prog_en = 1'b1;
    tick();
    chk("hold_rise", core_hold, 1);
    chk("s_hold_rise", s_hold, 1);
    lpm_req = 1'b1;
    foreach (q[i]) begin
      prog_byte = q[i];
      prog_strobe = 1'b1;
      tick();
      prog_strobe = 1'b0;
      tick();
      chk("hold_mid", core_hold, 1);
      chk("s_hold_mid", s_hold, 1);
      chk("done_mid", prog_done, 0);
      @(negedge clk);
      #1;
      chk("nop_fetch", data, 16'h0000);
      chk("lpm_blocked", lpm_valid, 0);
    end
    lpm_req = 1'b0;
    prog_en = 1'b0;
    tick();
    chk("done_pulse", prog_done, 1);
    chk("s_done_pulse", s_done, 1);
    chk("hold_in_done", core_hold, 1);
    tick();
    chk("done_end", prog_done, 0);
    chk("hold_fall", core_hold, 0);
    chk("s_hold_fall", s_hold, 0);
    for (int i = 0; i < n / 2; i++) begin
      mb[i] = {q[2*i+1], q[2*i]};
      vb[i] = 1'b1;
      if (i < 4) begin
        ms[i] = {q[2*i+1], q[2*i]};
        vs[i] = 1'b1;
      end
    end
    chk("ovf", prog_ovf, 0);
    chk("s_ovf", s_ovf, (n > 8) ? 1 : 0);
  endtask

  task automatic check_word(input int a);
    logic hb;
    hb = 1'($urandom_range(0, 1));
    addr = 10'(a);
    lpm_addr = {10'(a), hb};
    s_addr = 2'(a);
    s_lpm_addr = {2'(a), hb};
    lpm_req = 1'b1;
    @(negedge clk);
    #1;
    if (vb[a]) begin
      chk("fetch", data, mb[a]);
      chk("lpm_byte", lpm_data, hb ? mb[a][15:8] : mb[a][7:0]);
    end
    chk("lpm_valid", lpm_valid, 1);
    if (vs[a % 4]) begin
      chk("s_fetch", s_data, ms[a % 4]);
      chk("s_lpm_byte", s_lpm_data, hb ? ms[a % 4][15:8] : ms[a % 4][7:0]);
    end
    lpm_req = 1'b0;
    @(negedge clk);
    #1;
    chk("lpm_idle", lpm_valid, 0);
  endtask

  task automatic lpm_chk(input int ba, input logic [7:0] exp);
    lpm_addr = 11'(ba);
    lpm_req = 1'b1;
    @(negedge clk);
    #1;
    chk("lpm_fixed", lpm_data, exp);
    chk("lpm_fixed_valid", lpm_valid, 1);
    lpm_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    addr = '0;
    s_addr = '0;
    lpm_req = 1'b0;
    lpm_addr = '0;
    s_lpm_addr = '0;
    prog_en = 1'b0;
    prog_byte = '0;
    prog_strobe = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_data", data, 0);
    chk("rst_lpm_data", lpm_data, 0);
    chk("rst_lpm_valid", lpm_valid, 0);
    chk("rst_hold", core_hold, 0);
    chk("rst_done", prog_done, 0);
    chk("rst_ovf", prog_ovf, 0);
    tick();
    rst = 1'b0;
    tick();
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
    q.push_back(8'h0A);
    q.push_back(8'hE4);
    session();
    check_word(5);
    chk("fetch_e40a", data, 16'hE40A);
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_data", data, 0);
    tick();
    rst = 1'b0;
    tick();
    q = {8'h26, 8'hC0, 8'hCD, 8'hB7};
    session();
    check_word(0);
    check_word(1);
    chk("fetch_b7cd", data, 16'hB7CD);
    lpm_chk(3, 8'hB7);
    lpm_chk(2, 8'hCD);
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
    session();
    for (int a = 0; a < 5; a++) check_word(a);
    q = {8'($urandom), 8'($urandom), 8'($urandom)};
    session();
    check_word(0);
    check_word(1);
    q = {8'($urandom), 8'($urandom)};
    session();
    check_word(0);
    check_word(1);
    prog_en = 1'b1;
    tick();
    prog_byte = 8'h5A;
    prog_strobe = 1'b1;
    tick();
    prog_strobe = 1'b0;
    prog_byte = 8'hA5;
    tick();
    prog_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_hi_hold", core_hold, 0);
    chk("rst_hi_s_hold", s_hold, 0);
    chk("rst_hi_ovf", s_ovf, 0);
    tick();
    rst = 1'b0;
    tick();
    check_word(0);
    check_word(1);
    repeat (6) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(0, 14)); i++) q.push_back(8'($urandom));
      session();
      for (int a = 0; a < 8; a++) check_word(a);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_mem.md
# prog_mem

Loadable program memory for the ATtiny20 core, replacing the fixed, synthesised instruction table. It supplies 16-bit instructions to the core's fetch stage, serves byte reads for `lpm`, and accepts a new program image as a little-endian byte stream while the core is held. Read timing matches the existing fetch path: data registered on the falling edge, so the core samples it at the next rising edge.

## Interface
- `DATA_WIDTH`, 16, instruction word width (fixed at 16 for AVR; parameter kept for width checks)
- `ADDR_WIDTH`, 10, word address width; depth = 2**ADDR_WIDTH words (default 2 KiB)
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `addr`  in  ADDR_WIDTH  fetch word address (program counter)
- `data`  out  DATA_WIDTH  fetched instruction
- `lpm_req`  in  1  byte read request
- `lpm_addr`  in  ADDR_WIDTH+1  byte address; bit 0 selects high byte
- `lpm_data`  out  8  byte read result
- `lpm_valid`  out  1  lpm_data holds the result for the current request
- `prog_en`  in  1  programming session active (level)
- `prog_byte`  in  8  image byte
- `prog_strobe`  in  1  prog_byte valid this cycle
- `core_hold`  out  1  core must stall; high for the whole session
- `prog_done`  out  1  one-cycle pulse at session end
- `prog_ovf`  out  1  sticky; bytes arrived after memory was full

## Operation
- Storage: 2**ADDR_WIDTH × 16 array, one write port, two read ports. Not cleared by reset.
- Fetch: at each falling edge, `data` <= mem[`addr`]. While `core_hold` is high, `data` <= 16'h0000 (nop).
- LPM: at each falling edge, `lpm_data` <= the byte of mem[`lpm_addr`>>1] selected by `lpm_addr`[0] (0 = bits 7:0). `lpm_valid` <= `lpm_req` & ~`core_hold`.
- Loader FSM (rising edge): IDLE, LO, HI, WR, DONE.
  - IDLE, `prog_en`=1: word counter <= 0, `prog_ovf` <= 0, go to LO. `core_hold` is high in every state except IDLE.
  - LO, strobe: latch low byte, go to HI.
  - HI, strobe: latch high byte, go to WR.
  - WR: write {hi,lo} at the counter, increment the counter, go to LO.
  - Full: after the write to the last address, a full flag sets. Later strobes are dropped and set `prog_ovf`. There is no wrap-around.
  - `prog_en`=0 in LO, HI or WR: go to DONE. A pending WR completes first. A lone latched low byte is discarded.
  - DONE: `prog_done`=1 for one cycle, then go to IDLE.
- A strobe in IDLE or DONE is ignored.

## Timing
- Reset values: `data`=0, `lpm_data`=0, `lpm_valid`=0, `core_hold`=0, `prog_done`=0, `prog_ovf`=0, FSM in IDLE, counter 0.
- Fetch and LPM latency: half a cycle (address at a rising edge, result valid after the following falling edge).
- Write visibility: a word written at rising edge N can be read at falling edge N (same cycle) by either port.
- `core_hold` rises one rising edge after `prog_en` is sampled high. It falls on the edge that leaves DONE.
- Strobes may be back-to-back; the FSM accepts at most one byte per cycle. In WR the strobe is not accepted. The source must hold the byte until it sees LO again, or keep at least one idle cycle per word.
- Reset mid-session: immediate return to IDLE, hold released, partial word lost. Words already written are retained.

## Structure
- Package `attiny_pkg`: `NOP_WORD` (16'h0000), the loader state enum, and the `INSTR_W`=16 constant.
- Sub-module `prog_loader`: holds the FSM, counter, byte latches, full/ovf flags, and write-enable/addr/data outputs.
- `prog_mem` holds the array and both falling-edge read registers.

## Test plan
- Reset, then `addr`=5 with mem[5]=16'hE40A → `data`=16'hE40A after the first falling edge. Asserting `rst` mid-cycle forces `data`=0.
- Session writes bytes 0x26,0xC0,0xCD,0xB7 → mem[0]=16'hC026, mem[1]=16'hB7CD. `core_hold` is high throughout. `prog_done` pulses once. Fetch of addr 1 afterwards → 16'hB7CD.
- `lpm_req` with `lpm_addr`=3 after the previous test → `lpm_data`=0xB7, `lpm_valid`=1. With `lpm_addr`=2 → 0xCD. During a session → `lpm_valid`=0 and `data`=0.
- ADDR_WIDTH=2: 10 bytes streamed → 4 words written, `prog_ovf`=1, mem[0] unchanged by bytes 9 and 10.
- `prog_en` dropped after 3 bytes → word 0 written, third byte discarded, `prog_done` pulses, counter restarts at 0 on the next session.
- `rst` asserted in state HI → FSM in IDLE, `core_hold`=0 within the same cycle, and the partial word is not written.
